// File: rtl/bcd_date_counter.sv
// BCD calendar date counter (YY/MM/DD) with day advance and checked load.
// Optional LEAP_YEAR_EN macro enables 29-day February in years divisible by 4.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   day_tick            advance the date by one day
//   load, load_*        load a new date (rejected if not a valid date)
//   year1..day0         registered BCD date digits
//   year_carry          one-cycle pulse on the 12/31 -> 01/01 wrap
//   load_err            one-cycle pulse when a load is rejected
module bcd_date_counter #(
  parameter logic [7:0] INIT_YEAR  = 8'h19,
  parameter logic [7:0] INIT_MONTH = 8'h01,
  parameter logic [7:0] INIT_DAY   = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       day_tick,
  input  logic       load,
  input  logic [3:0] load_year1,
  input  logic [3:0] load_year0,
  input  logic [3:0] load_month1,
  input  logic [3:0] load_month0,
  input  logic [3:0] load_day1,
  input  logic [3:0] load_day0,
  output logic [3:0] year1,
  output logic [3:0] year0,
  output logic [3:0] month1,
  output logic [3:0] month0,
  output logic [3:0] day1,
  output logic [3:0] day0,
  output logic       year_carry,
  output logic       load_err
);

  logic [3:0] y1_q, y0_q, m1_q, m0_q, dd1_q, dd0_q;
  logic [3:0] y1_d, y0_d, m1_d, m0_d, dd1_d, dd0_d;
  logic       carry_q, carry_d;
  logic       err_q, err_d;

  logic       leap_cur, leap_ld;
  logic [7:0] max_cur, max_ld;
  logic [7:0] ld_mon, ld_day;
  logic       digits_ok, ld_ok;

  // Days in a BCD month; invalid months fall into the 30 bucket and are
  // screened out separately by the load check.
  function automatic logic [7:0] max_day(
    input logic [7:0] mon,
    input logic       leap
  );
    logic [7:0] r;
    unique case (mon)
      8'h01, 8'h03, 8'h05, 8'h07,
      8'h08, 8'h10, 8'h12: r = 8'h31;
      8'h02:               r = leap ? 8'h29 : 8'h28;
      default:             r = 8'h30;
    endcase
    return r;
  endfunction

  // Year divisible by 4 (century ignored): tens parity picks ones set.
  function automatic logic is_leap(
    input logic [3:0] t,
    input logic [3:0] o
  );
    logic even_ok, odd_ok;
    even_ok = (o == 4'd0) || (o == 4'd4) || (o == 4'd8);
    odd_ok  = (o == 4'd2) || (o == 4'd6);
    return t[0] ? odd_ok : even_ok;
  endfunction

`ifdef LEAP_YEAR_EN
  assign leap_cur = is_leap(y1_q, y0_q);
  assign leap_ld  = is_leap(load_year1, load_year0);
`else
  assign leap_cur = 1'b0;
  assign leap_ld  = 1'b0;
`endif

  assign ld_mon  = {load_month1, load_month0};
  assign ld_day  = {load_day1, load_day0};
  assign max_cur = max_day({m1_q, m0_q}, leap_cur);
  assign max_ld  = max_day(ld_mon, leap_ld);

  assign digits_ok = (load_year1 <= 4'd9) && (load_year0 <= 4'd9) &&
                     (load_month1 <= 4'd9) && (load_month0 <= 4'd9) &&
                     (load_day1 <= 4'd9) && (load_day0 <= 4'd9);

  // With all digits decimal, BCD pairs order the same as binary.
  assign ld_ok = digits_ok &&
                 (ld_mon >= 8'h01) && (ld_mon <= 8'h12) &&
                 (ld_day >= 8'h01) && (ld_day <= max_ld);

  always_comb begin
    y1_d    = y1_q;
    y0_d    = y0_q;
    m1_d    = m1_q;
    m0_d    = m0_q;
    dd1_d   = dd1_q;
    dd0_d   = dd0_q;
    carry_d = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      // A load always consumes the cycle; any tick is dropped.
      if (ld_ok) begin
        y1_d  = load_year1;
        y0_d  = load_year0;
        m1_d  = load_month1;
        m0_d  = load_month0;
        dd1_d = load_day1;
        dd0_d = load_day0;
      end else begin
        err_d = 1'b1;
      end
    end else if (day_tick) begin
      if ({dd1_q, dd0_q} == max_cur) begin
        dd1_d = 4'd0;
        dd0_d = 4'd1;
        if ({m1_q, m0_q} == 8'h12) begin
          m1_d    = 4'd0;
          m0_d    = 4'd1;
          carry_d = 1'b1;
          if (y0_q == 4'd9) begin
            y0_d = 4'd0;
            y1_d = (y1_q == 4'd9) ? 4'd0 : y1_q + 4'd1;
          end else begin
            y0_d = y0_q + 4'd1;
          end
        end else if (m0_q == 4'd9) begin
          m1_d = 4'd1;
          m0_d = 4'd0;
        end else begin
          m0_d = m0_q + 4'd1;
        end
      end else if (dd0_q == 4'd9) begin
        dd0_d = 4'd0;
        dd1_d = dd1_q + 4'd1;
      end else begin
        dd0_d = dd0_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y1_q    <= INIT_YEAR[7:4];
      y0_q    <= INIT_YEAR[3:0];
      m1_q    <= INIT_MONTH[7:4];
      m0_q    <= INIT_MONTH[3:0];
      dd1_q   <= INIT_DAY[7:4];
      dd0_q   <= INIT_DAY[3:0];
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      y1_q    <= y1_d;
      y0_q    <= y0_d;
      m1_q    <= m1_d;
      m0_q    <= m0_d;
      dd1_q   <= dd1_d;
      dd0_q   <= dd0_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign year1      = y1_q;
  assign year0      = y0_q;
  assign month1     = m1_q;
  assign month0     = m0_q;
  assign day1       = dd1_q;
  assign day0       = dd0_q;
  assign year_carry = carry_q;
  assign load_err   = err_q;

endmodule
